// File: rtl/riscv_result_dumper_if.sv
// Bus bundle between the result dumper, the data-memory read port and the stream sink.
// master = dumper side; slave = memory/sink side.
interface riscv_result_dumper_if;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/riscv_result_dumper.sv
// Post-run readout: on a rising done, snapshot CPU counters, stream the result matrix
// from data memory, then the cycle and instruction counts, over a valid/ready link.
//
// state  | meaning
// IDLE   | waiting for the first done edge since reset
// REQ    | read strobe issued for result word idx
// WAIT   | memory returns data at the end of this cycle
// SEND   | result word presented, waiting for handshake
// TRL_CC | cycle-count snapshot presented
// TRL_IC | instruction-count snapshot presented (last word)
// FIN    | dump complete, finished held until the next trigger
module riscv_result_dumper #(
  parameter int unsigned M        = 100,
  parameter int unsigned N        = 50,
  parameter int unsigned N2       = 2,
  parameter int unsigned RES_BASE = M * N + N * N2,
  parameter int unsigned RES_LEN  = M * N2
) (
  input  logic                         CLOCK_50,
  input  logic                         rstn,
  input  logic                         done,
  input  logic [31:0]                  clock_count,
  input  logic [31:0]                  instr_cnt,
  riscv_result_dumper_if.master        bus,
  output logic                         busy,
  output logic                         finished
);

  if (RES_LEN == 0) begin : g_len_check
    $error("riscv_result_dumper: RES_LEN must be at least 1");
  end

  localparam logic [31:0] BASE     = 32'(RES_BASE);
  localparam logic [31:0] LAST_IDX = 32'(RES_LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, TRL_CC, TRL_IC, FIN} state_t;

  state_t      state, state_d;
  logic [31:0] idx, idx_d;
  logic [31:0] cc_snap, cc_snap_d;
  logic [31:0] ic_snap, ic_snap_d;
  logic        done_q;
  logic        trigger;
  logic        handshake;
  logic        rd_en_d, valid_d, last_d, busy_d, finished_d;
  logic [31:0] addr_d, data_d;

  assign trigger   = done && !done_q;
  assign handshake = bus.out_valid && bus.out_ready;

  // Next values of every registered output are computed here so outputs stay glitch-free.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    cc_snap_d  = cc_snap;
    ic_snap_d  = ic_snap;
    rd_en_d    = 1'b0;
    addr_d     = bus.mem_addr;
    data_d     = bus.out_data;
    valid_d    = bus.out_valid;
    last_d     = bus.out_last;
    finished_d = finished;
    case (state)
      IDLE, FIN: begin
        if (trigger) begin
          state_d    = REQ;
          cc_snap_d  = clock_count;
          ic_snap_d  = instr_cnt;
          idx_d      = '0;
          finished_d = 1'b0;
          rd_en_d    = 1'b1;
          addr_d     = BASE;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        state_d = SEND;
        data_d  = bus.mem_rdata;
        valid_d = 1'b1;
      end
      SEND: begin
        if (handshake) begin
          idx_d = idx + 32'd1;
          if (idx == LAST_IDX) begin
            state_d = TRL_CC;
            data_d  = cc_snap;
            valid_d = 1'b1;
          end else begin
            state_d = REQ;
            valid_d = 1'b0;
            rd_en_d = 1'b1;
            addr_d  = BASE + idx + 32'd1;
          end
        end
      end
      TRL_CC: begin
        if (handshake) begin
          state_d = TRL_IC;
          data_d  = ic_snap;
          last_d  = 1'b1;
        end
      end
      TRL_IC: begin
        if (handshake) begin
          state_d    = FIN;
          valid_d    = 1'b0;
          last_d     = 1'b0;
          finished_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == REQ) || (state_d == WAIT) || (state_d == SEND) ||
             (state_d == TRL_CC) || (state_d == TRL_IC);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      state         <= IDLE;
      idx           <= '0;
      cc_snap       <= '0;
      ic_snap       <= '0;
      done_q        <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      finished      <= 1'b0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      cc_snap       <= cc_snap_d;
      ic_snap       <= ic_snap_d;
      done_q        <= done;
      bus.mem_rd_en <= rd_en_d;
      bus.mem_addr  <= addr_d;
      bus.out_valid <= valid_d;
      bus.out_data  <= data_d;
      bus.out_last  <= last_d;
      busy          <= busy_d;
      finished      <= finished_d;
    end
  end

endmodule

// File: tb/tb_riscv_result_dumper.sv
// Directed bench for riscv_result_dumper with a 2x2x2 geometry (result words at 8..11).
module tb_riscv_result_dumper;
  logic        CLOCK_50 = 1'b0;
  logic        rstn;
  logic        done;
  logic [31:0] clock_count;
  logic [31:0] instr_cnt;
  logic        busy;
  logic        finished;

  riscv_result_dumper_if bus ();

  riscv_result_dumper #(.M(2), .N(2), .N2(2)) dut (
    .CLOCK_50    (CLOCK_50),
    .rstn        (rstn),
    .done        (done),
    .clock_count (clock_count),
    .instr_cnt   (instr_cnt),
    .bus         (bus),
    .busy        (busy),
    .finished    (finished)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [31:0] mem [0:15];
  logic [31:0] rx_data [$];
  logic        rx_last [$];
  int          rd_total   = 0;
  int          stall_total = 0;
  int          viol       = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;
  int          n_checks   = 0;
  int          n_pass     = 0;

  always @(posedge CLOCK_50) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[3:0]];
  end

  // Sink/monitor: records handshakes, read strobes, stalls and stall-stability violations.
  always @(posedge CLOCK_50) begin
    if (rstn) begin
      if (bus.out_valid && bus.out_ready) begin
        rx_data.push_back(bus.out_data);
        rx_last.push_back(bus.out_last);
      end
      if (bus.out_valid && !bus.out_ready) stall_total++;
      if (bus.mem_rd_en) rd_total++;
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        viol++;
    end
    prev_stall = rstn && bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
  end

  int rd_base, stall_base, viol_base;

  task automatic start_dump();
    @(negedge CLOCK_50);
    done = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    rx_data.delete();
    rx_last.delete();
    rd_base    = rd_total;
    stall_base = stall_total;
    viol_base  = viol;
    done = 1'b1;
  endtask

  task automatic wait_finished(output int cyc, output bit timeout);
    cyc = 0;
    timeout = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      cyc++;
      if (finished) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit to;
    rstn = 1'b0;
    done = 1'b1;
    bus.out_ready = 1'b1;
    clock_count = 32'd1234;
    instr_cnt   = 32'd56;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_checks++;
    if ({bus.mem_rd_en, bus.out_valid, bus.out_last, busy, finished} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {bus.mem_rd_en, bus.out_valid, bus.out_last, busy, finished});
    else n_pass++;
    n_checks++;
    if (bus.mem_addr !== 32'd0 || bus.out_data !== 32'd0)
      $display("FAIL reset_data: addr %0d data %0d want 0 0", bus.mem_addr, bus.out_data);
    else n_pass++;
    rx_data.delete();
    rx_last.delete();
    rd_base = rd_total;
    rstn = 1'b1;
    wait_finished(cyc, to);
    n_checks++;
    if (to) $display("FAIL reset_dump_timeout: finished never rose");
    else n_pass++;
    repeat (20) @(negedge CLOCK_50);
    n_checks++;
    if (rx_data.size() != 6 || rd_total - rd_base != 4)
      $display("FAIL reset_single_dump: words %0d reads %0d want 6 4",
               rx_data.size(), rd_total - rd_base);
    else n_pass++;
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    logic [31:0] exp_d [6];
    exp_d = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd1234, 32'd56};
    clock_count = 32'd1234;
    instr_cnt   = 32'd56;
    start_dump();
    @(negedge CLOCK_50);
    n_checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'd8 || busy !== 1'b1 || finished !== 1'b0)
      $display("FAIL basic_req: rd %b addr %0d busy %b fin %b want 1 8 1 0",
               bus.mem_rd_en, bus.mem_addr, busy, finished);
    else n_pass++;
    @(negedge CLOCK_50);
    n_checks++;
    if (bus.mem_rd_en !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL basic_wait: rd %b valid %b want 0 0", bus.mem_rd_en, bus.out_valid);
    else n_pass++;
    @(negedge CLOCK_50);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd11)
      $display("FAIL basic_first_word: valid %b data %0d want 1 11", bus.out_valid, bus.out_data);
    else n_pass++;
    wait_finished(cyc, to);
    n_checks++;
    if (to || cyc + 2 != 14)
      $display("FAIL basic_latency: finished after %0d cycles (timeout %b) want 14", cyc + 2, to);
    else n_pass++;
    n_checks++;
    if (rx_data.size() != 6) $display("FAIL basic_count: got %0d words want 6", rx_data.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < rx_data.size(); i++) begin
      n_checks++;
      if (rx_data[i] !== exp_d[i] || rx_last[i] !== (i == 5))
        $display("FAIL basic_word%0d: data %0d last %b want %0d %b",
                 i, rx_data[i], rx_last[i], exp_d[i], (i == 5));
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    bit seen;
    clock_count = 32'd5000;
    instr_cnt   = 32'd77;
    start_dump();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (finished) begin
        seen = 1'b1;
        break;
      end
      clock_count = clock_count + 32'd1;
      instr_cnt   = instr_cnt + 32'd3;
    end
    n_checks++;
    if (!seen || rx_data.size() != 6)
      $display("FAIL snap_count: words %0d done %b want 6 1", rx_data.size(), seen);
    else n_pass++;
    n_checks++;
    if (rx_data.size() == 6 && (rx_data[4] !== 32'd5000 || rx_data[5] !== 32'd77))
      $display("FAIL snap_values: cc %0d ic %0d want 5000 77", rx_data[4], rx_data[5]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc;
    int stall_n;
    bit seen;
    logic [31:0] exp_d [6];
    exp_d = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd1234, 32'd56};
    clock_count = 32'd1234;
    instr_cnt   = 32'd56;
    start_dump();
    stall_n = 0;
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      cyc++;
      if (finished) begin
        seen = 1'b1;
        break;
      end
      if (bus.out_valid && bus.out_data == 32'd22 && stall_n < 5) begin
        bus.out_ready = 1'b0;
        stall_n++;
      end else if (bus.out_valid && (bus.out_data == 32'd1234 || bus.out_data == 32'd56))
        bus.out_ready = 1'($urandom_range(0, 1));
      else
        bus.out_ready = 1'b1;
    end
    bus.out_ready = 1'b1;
    n_checks++;
    if (!seen || stall_n != 5)
      $display("FAIL bp_progress: finished %b stalls on 22 %0d want 1 5", seen, stall_n);
    else n_pass++;
    n_checks++;
    if (viol - viol_base != 0)
      $display("FAIL bp_stable: %0d outputs changed while stalled want 0", viol - viol_base);
    else n_pass++;
    n_checks++;
    if (rd_total - rd_base != 4)
      $display("FAIL bp_reads: %0d read strobes want 4", rd_total - rd_base);
    else n_pass++;
    n_checks++;
    if (cyc - 1 != 14 + (stall_total - stall_base))
      $display("FAIL bp_cycles: %0d cycles want %0d", cyc - 1, 14 + (stall_total - stall_base));
    else n_pass++;
    n_checks++;
    if (rx_data.size() != 6) $display("FAIL bp_count: got %0d words want 6", rx_data.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < rx_data.size(); i++) begin
      n_checks++;
      if (rx_data[i] !== exp_d[i] || rx_last[i] !== (i == 5))
        $display("FAIL bp_word%0d: data %0d last %b want %0d %b",
                 i, rx_data[i], rx_last[i], exp_d[i], (i == 5));
      else n_pass++;
    end
  endtask

  task automatic test_retrigger();
    int cyc;
    bit to;
    logic [31:0] exp_d [6];
    exp_d = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd1234, 32'd56};
    rx_data.delete();
    rx_last.delete();
    repeat (20) @(negedge CLOCK_50);
    n_checks++;
    if (rx_data.size() != 0 || finished !== 1'b1 || busy !== 1'b0)
      $display("FAIL retrig_held_done: words %0d fin %b busy %b want 0 1 0",
               rx_data.size(), finished, busy);
    else n_pass++;
    done = 1'b0;
    @(negedge CLOCK_50);
    done = 1'b1;
    @(negedge CLOCK_50);
    n_checks++;
    if (finished !== 1'b0 || busy !== 1'b1)
      $display("FAIL retrig_start: fin %b busy %b want 0 1", finished, busy);
    else n_pass++;
    wait_finished(cyc, to);
    n_checks++;
    if (to || rx_data.size() != 6)
      $display("FAIL retrig_count: words %0d timeout %b want 6 0", rx_data.size(), to);
    else n_pass++;
    for (int i = 0; i < 6 && i < rx_data.size(); i++) begin
      n_checks++;
      if (rx_data[i] !== exp_d[i])
        $display("FAIL retrig_word%0d: data %0d want %0d", i, rx_data[i], exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    bit seen;
    clock_count = 32'd1234;
    instr_cnt   = 32'd56;
    start_dump();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      if (bus.out_valid && bus.out_data == 32'd33) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL mid_reach33: word 33 never presented");
    else n_pass++;
    rstn = 1'b0;
    done = 1'b0;
    @(negedge CLOCK_50);
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.mem_rd_en !== 1'b0)
      $display("FAIL mid_abort: valid %b busy %b rd %b want 0 0 0",
               bus.out_valid, busy, bus.mem_rd_en);
    else n_pass++;
    rstn = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    n_checks++;
    if (rx_data.size() != 2 || busy !== 1'b0)
      $display("FAIL mid_idle: words %0d busy %b want 2 0", rx_data.size(), busy);
    else n_pass++;
    rx_data.delete();
    rx_last.delete();
    done = 1'b1;
    wait_finished(cyc, to);
    n_checks++;
    if (to || rx_data.size() != 6)
      $display("FAIL mid_redump_count: words %0d timeout %b want 6 0", rx_data.size(), to);
    else n_pass++;
    n_checks++;
    if (rx_data.size() == 6 && (rx_data[0] !== 32'd11 || rx_data[3] !== 32'd44 || rx_data[5] !== 32'd56))
      $display("FAIL mid_redump_words: %0d %0d %0d want 11 44 56", rx_data[0], rx_data[3], rx_data[5]);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    mem[8]  = 32'd11;
    mem[9]  = 32'd22;
    mem[10] = 32'd33;
    mem[11] = 32'd44;
    test_reset();
    test_basic();
    test_snapshot();
    test_backpressure();
    test_retrigger();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
